onewire_master: RTL
===================

# onewire_master

Single-wire open-drain bus master that drives one bidirectional pad through the tristate IO buffer's `D`/`E`/`Y` pins. It generates 1-Wire reset/presence sequences and byte-wide write/read time slots from a simple valid/ready command interface. It sits between the board-management logic (sensor and ID readout) and the pad buffer instance, and is the driving end of the pad's output-enable/input-sample interface.

## Interface
- `TICK_DIV`, default 100: clock cycles per 1 µs time unit (100 MHz CLK). Legal range is ≥ 2.
- `CLK` in 1: system clock. All logic is on the rising edge.
- `RESET_N` in 1: reset, asynchronous assert, active-low. Deassertion is synchronous to `CLK` upstream.
- `CMD_VALID` in 1: command request.
- `CMD_READY` out 1: block idle and able to accept a command.
- `CMD_OP` in 2: `00` reset/presence, `01` write byte, `10` read byte, `11` no-op.
- `CMD_DATA` in 8: byte to write. Sent LSB first.
- `RSP_VALID` out 1: one-cycle pulse at command completion.
- `RSP_DATA` out 8: byte read. LSB was received first.
- `RSP_PRESENCE` out 1: presence detected in the last reset.
- `IO_D` out 1: pad buffer data. Constant 0 (open-drain).
- `IO_E` out 1: pad buffer output enable. 1 = pull bus low.
- `IO_Y` in 1: pad buffer input, asynchronous to `CLK`.

## Operation
- Handshake
  - A command is accepted on a cycle with `CMD_VALID && CMD_READY`.
  - `CMD_OP` and `CMD_DATA` are captured on that cycle.
  - `CMD_READY` drops on the next cycle.
- Input sampling: `IO_Y` passes through a 2-FF synchronizer, which adds 2 cycles of latency. Only the synchronized value is used.
- Timebase
  - A prescaler counts `TICK_DIV` cycles per µs.
  - The prescaler is cleared on command accept, so all phases are exact multiples of `TICK_DIV` cycles from the first `IO_E` assertion.
  - A µs counter of 10 bits counts within each phase.
- States: IDLE, RST_LOW, RST_WAIT, RST_REC, SLOT_LOW, SLOT_REL, SLOT_REC, DONE.
- IDLE
  - `IO_E`=0, `CMD_READY`=1.
  - On accept: op `00` → RST_LOW; ops `01`/`10` → SLOT_LOW with bit index 0; op `11` → DONE.
- Reset sequence (op `00`)
  - RST_LOW: `IO_E`=1 for 480 µs, then → RST_WAIT.
  - RST_WAIT: `IO_E`=0 for 70 µs. On the last cycle, presence = (synchronized `IO_Y`==0). Then → RST_REC.
  - RST_REC: `IO_E`=0 for 410 µs, then → DONE.
- Slot (70 µs total per bit)
  - SLOT_LOW: `IO_E`=1 for 60 µs if writing 0, otherwise for 6 µs (write 1 and all read slots).
  - SLOT_REL: released until 15 µs from slot start. This state is skipped when the low phase was 60 µs. For reads, the synchronized `IO_Y` is sampled on the last cycle of this state into shift register bit [index].
  - SLOT_REC: released until 70 µs from slot start. Then, if index==7 → DONE; otherwise index+1 → SLOT_LOW.
- DONE
  - Single cycle: `RSP_VALID`=1. `RSP_DATA` is updated only for op `10`. `RSP_PRESENCE` is updated only for op `00`.
  - → IDLE. `CMD_READY` returns to 1 on the cycle after DONE.
- `RSP_DATA` and `RSP_PRESENCE` hold their values until the next command of the same kind completes.
- `CMD_VALID` while busy is ignored (not queued).
- Write-byte (op `01`) completion leaves `RSP_DATA` unchanged.
- `IO_E` is driven from a register; it is never driven combinationally.

## Timing
- Reset values: `IO_D`=0, `IO_E`=0, `CMD_READY`=1, `RSP_VALID`=0, `RSP_DATA`=0x00, `RSP_PRESENCE`=0, state IDLE, counters and synchronizer cleared.
- `IO_E` rises 1 cycle after the accept cycle.
- Reset latency: 960·`TICK_DIV` cycles of bus activity. `RSP_VALID` is 1 cycle after that, and `CMD_READY` 1 cycle after `RSP_VALID`.
- Byte latency: 8·70·`TICK_DIV` cycles of bus activity, followed by the same `RSP_VALID` / `CMD_READY` sequence as reset.
- No-op latency: `RSP_VALID` 1 cycle after accept.
- Read sample point: 15 µs after slot start, minus the 2-cycle synchronizer delay relative to the pad.
- `RESET_N` assertion mid-operation: `IO_E`=0 immediately (asynchronously), releasing the bus. After deassertion the block is in IDLE. No `RSP_VALID` is produced for the aborted command.
- Slave holding the bus low past 70 µs in RST_WAIT: still reported as presence=1; no timeout.

## Test plan
- `TICK_DIV`=4, reset op, bus model pulls `IO_Y` low from 15 to 135 µs after release → `IO_E` high for exactly 1920 cycles; `RSP_VALID` at 3841 cycles after accept; `RSP_PRESENCE`=1.
- Reset op with no slave (`IO_Y` always 1) → `RSP_PRESENCE`=0; `RSP_DATA` unchanged.
- Write byte 0xA5 → eight slots of 280 cycles each. Low widths in cycles are 24, 240, 24, 240, 240, 24, 240, 24 (LSB first). `RSP_VALID` after 2240 cycles.
- Read byte, slave holds low across sample points for bits 1, 2, 4, 7 → `RSP_DATA`=0x69; each slot has 24-cycle low.
- `CMD_VALID` held high throughout, ops 01 then 11 → the second command is accepted only after `CMD_READY` returns. No-op gives `RSP_VALID` 1 cycle after accept with no `IO_E` activity.
- `RESET_N` pulsed low during SLOT_LOW of a write-0 → `IO_E` falls in the same cycle; all outputs equal reset values; the next reset op completes normally.

Source files
------------

// File: rtl/onewire_master.sv
// onewire_master
// Open-drain 1-Wire bus master. Accepts reset/presence, write-byte, read-byte
// and no-op commands over a valid/ready interface and runs the matching time
// slots on a single pad through a tristate buffer (D tied low, E = pull low).
//
// Ports:
//   CLK, RESET_N          clock, asynchronous active-low reset
//   CMD_VALID/CMD_READY   command handshake
//   CMD_OP                00 reset/presence, 01 write byte, 10 read byte, 11 no-op
//   CMD_DATA              byte to write, LSB first
//   RSP_VALID             one-cycle completion pulse
//   RSP_DATA              last byte read (LSB received first)
//   RSP_PRESENCE          presence result of the last reset sequence
//   IO_D, IO_E, IO_Y      pad buffer data (always 0), output enable, input
module onewire_master #(
    parameter int TICK_DIV = 100
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       CMD_VALID,
    output logic       CMD_READY,
    input  logic [1:0] CMD_OP,
    input  logic [7:0] CMD_DATA,
    output logic       RSP_VALID,
    output logic [7:0] RSP_DATA,
    output logic       RSP_PRESENCE,
    output logic       IO_D,
    output logic       IO_E,
    input  logic       IO_Y
);
    localparam int PW = $clog2(TICK_DIV);

    localparam logic [1:0] OP_RESET = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RST_LOW  = 3'd1,
        ST_RST_WAIT = 3'd2,
        ST_RST_REC  = 3'd3,
        ST_SLOT_LOW = 3'd4,
        ST_SLOT_REL = 3'd5,
        ST_SLOT_REC = 3'd6,
        ST_DONE     = 3'd7
    } state_t;

    state_t          state_r;
    state_t          state_next_s;
    logic [1:0]      op_r;
    logic [7:0]      data_r;        // write byte, overwritten bitwise by read samples
    logic [2:0]      idx_r;
    logic            pres_r;
    logic [PW-1:0]   presc_r;
    logic [9:0]      us_cnt_r;
    logic            y_meta_r;
    logic            y_sync_r;
    logic            io_e_r;
    logic            ready_r;
    logic            rsp_valid_r;
    logic [7:0]      rsp_data_r;
    logic            rsp_pres_r;

    logic            accept_s;
    logic            tick_s;
    logic            low_long_s;
    logic [9:0]      phase_len_s;
    logic            phase_end_s;

    assign accept_s    = CMD_VALID && ready_r;
    assign tick_s      = (presc_r == PW'(TICK_DIV - 1));
    // Only a written 0 keeps the bus low for the long 60 us phase.
    assign low_long_s  = (op_r == OP_WRITE) && (data_r[idx_r] == 1'b0);
    assign phase_end_s = tick_s && (us_cnt_r == (phase_len_s - 10'd1));

    // Phase length in microseconds for the current state.
    always_comb begin
        phase_len_s = 10'd1;
        case (state_r)
            ST_RST_LOW:  phase_len_s = 10'd480;
            ST_RST_WAIT: phase_len_s = 10'd70;
            ST_RST_REC:  phase_len_s = 10'd410;
            ST_SLOT_LOW: phase_len_s = low_long_s ? 10'd60 : 10'd6;
            ST_SLOT_REL: phase_len_s = 10'd9;
            ST_SLOT_REC: phase_len_s = low_long_s ? 10'd10 : 10'd55;
            default:     phase_len_s = 10'd1;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    case (CMD_OP)
                        OP_RESET: state_next_s = ST_RST_LOW;
                        OP_WRITE: state_next_s = ST_SLOT_LOW;
                        OP_READ:  state_next_s = ST_SLOT_LOW;
                        default:  state_next_s = ST_DONE;
                    endcase
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RST_LOW: begin
                if (phase_end_s) state_next_s = ST_RST_WAIT;
                else             state_next_s = ST_RST_LOW;
            end
            ST_RST_WAIT: begin
                if (phase_end_s) state_next_s = ST_RST_REC;
                else             state_next_s = ST_RST_WAIT;
            end
            ST_RST_REC: begin
                if (phase_end_s) state_next_s = ST_DONE;
                else             state_next_s = ST_RST_REC;
            end
            ST_SLOT_LOW: begin
                if (phase_end_s) state_next_s = low_long_s ? ST_SLOT_REC : ST_SLOT_REL;
                else             state_next_s = ST_SLOT_LOW;
            end
            ST_SLOT_REL: begin
                if (phase_end_s) state_next_s = ST_SLOT_REC;
                else             state_next_s = ST_SLOT_REL;
            end
            ST_SLOT_REC: begin
                if (phase_end_s) state_next_s = (idx_r == 3'd7) ? ST_DONE : ST_SLOT_LOW;
                else             state_next_s = ST_SLOT_REC;
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register and registered control outputs (derived from next state).
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r     <= ST_IDLE;
            io_e_r      <= 1'b0;
            ready_r     <= 1'b1;
            rsp_valid_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            io_e_r      <= (state_next_s == ST_RST_LOW) || (state_next_s == ST_SLOT_LOW);
            ready_r     <= (state_next_s == ST_IDLE);
            rsp_valid_r <= (state_next_s == ST_DONE);
        end
    end

    // Two-flop synchronizer for the asynchronous pad input.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            y_meta_r <= 1'b0;
            y_sync_r <= 1'b0;
        end else begin
            y_meta_r <= IO_Y;
            y_sync_r <= y_meta_r;
        end
    end

    // Microsecond timebase; restarted on accept so phases align to IO_E rise.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            presc_r  <= '0;
            us_cnt_r <= 10'd0;
        end else if (accept_s || (state_r == ST_IDLE) || (state_r == ST_DONE)) begin
            presc_r  <= '0;
            us_cnt_r <= 10'd0;
        end else begin
            presc_r  <= tick_s ? '0 : (presc_r + 1'b1);
            if (phase_end_s)  us_cnt_r <= 10'd0;
            else if (tick_s)  us_cnt_r <= us_cnt_r + 10'd1;
            else              us_cnt_r <= us_cnt_r;
        end
    end

    // Command capture, bit index, read sampling and presence sampling.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            op_r   <= 2'b00;
            data_r <= 8'h00;
            idx_r  <= 3'd0;
            pres_r <= 1'b0;
        end else if (accept_s) begin
            op_r   <= CMD_OP;
            data_r <= CMD_DATA;
            idx_r  <= 3'd0;
        end else begin
            if ((state_r == ST_SLOT_REL) && phase_end_s && (op_r == OP_READ))
                data_r[idx_r] <= y_sync_r;
            if ((state_r == ST_SLOT_REC) && phase_end_s)
                idx_r <= idx_r + 3'd1;
            if ((state_r == ST_RST_WAIT) && phase_end_s)
                pres_r <= ~y_sync_r;
        end
    end

    // Response registers; a no-op goes straight from IDLE to DONE and updates nothing.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rsp_data_r <= 8'h00;
            rsp_pres_r <= 1'b0;
        end else if ((state_next_s == ST_DONE) && (state_r != ST_IDLE)) begin
            if (op_r == OP_READ)  rsp_data_r <= data_r;
            if (op_r == OP_RESET) rsp_pres_r <= pres_r;
        end
    end

    assign CMD_READY    = ready_r;
    assign RSP_VALID    = rsp_valid_r;
    assign RSP_DATA     = rsp_data_r;
    assign RSP_PRESENCE = rsp_pres_r;
    assign IO_D         = 1'b0;
    assign IO_E         = io_e_r;

endmodule
